// File: rtl/fetch_unit_pkg.sv
//------------------------------------------------------------------------------
// Module : fetch_unit_pkg
// Brief  : Shared widths, reset PC and fetch-queue entry type for the fetch unit
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef FETCH_UNIT_DEFINES
`define FETCH_UNIT_DEFINES
`define Inst_Width      32
`define Inst_Addr_Width 17
`endif

package fetch_unit_pkg;
  localparam int c_inst_w = `Inst_Width;
  localparam int c_addr_w = `Inst_Addr_Width;
  localparam logic [c_addr_w-1:0] c_reset_pc = '0;

  typedef struct packed {
    logic [c_inst_w-1:0] inst;
    logic [c_addr_w-1:0] pc;
  } fetch_entry_t;
endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
//------------------------------------------------------------------------------
// Module : fetch_unit_if
// Brief  : Icache request/response, redirect and decode handshake bundle
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if #(
  parameter int INST_W = fetch_unit_pkg::c_inst_w,
  parameter int ADDR_W = fetch_unit_pkg::c_addr_w,
  parameter int CNT_W  = 3
) ();
  logic              pc_icache_ce;
  logic [ADDR_W-1:0] icache_addr;
  logic              sta_icache_stall;
  logic              icache_dec_enable;
  logic [INST_W-1:0] icache_dec_inst;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              dec_valid;
  logic              dec_ready;
  logic [INST_W-1:0] dec_inst;
  logic [ADDR_W-1:0] dec_pc;
  logic [CNT_W-1:0]  fq_count;

  modport master (
    output pc_icache_ce, icache_addr, dec_valid, dec_inst, dec_pc, fq_count,
    input  sta_icache_stall, icache_dec_enable, icache_dec_inst,
           redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  pc_icache_ce, icache_addr, dec_valid, dec_inst, dec_pc, fq_count,
    output sta_icache_stall, icache_dec_enable, icache_dec_inst,
           redirect_valid, redirect_pc, dec_ready
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
//------------------------------------------------------------------------------
// Module : fetch_fifo
// Brief  : Synchronous DEPTH-entry FIFO with flush taking priority over push/pop
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_fifo #(
  parameter int W     = 49,
  parameter int DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       i_push,
  input  wire logic                       i_pop,
  input  wire logic                       i_flush,
  input  wire logic [W-1:0]               i_din,
  output logic      [W-1:0]               o_dout,
  output logic      [$clog2(DEPTH+1)-1:0] o_count,
  output logic                            o_full,
  output logic                            o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_head];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (rst && !i_flush && w_push) r_mem[r_tail] <= i_din;
  end
endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module : fetch_unit
// Brief  : PC generator driving the icache plus fetch queue feeding decode
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                INST_W   = c_inst_w,
  parameter int                ADDR_W   = c_addr_w,
  parameter int                DEPTH    = 4,
  parameter int                PC_INC   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_reset_pc)
) (
  input wire logic     clk,
  input wire logic     rst,
  fetch_unit_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0]        r_pc;
  logic                     w_ce;
  logic                     w_accept;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic [INST_W+ADDR_W-1:0] w_head;
  logic [CNT_W-1:0]         w_count;

  // Full blocks the request even if decode pops this cycle: avoids a ready->ce path.
  assign w_ce     = rst & ~w_full & ~bus.redirect_valid;
  assign w_accept = w_ce & bus.icache_dec_enable & ~bus.sta_icache_stall;
  assign w_pop    = ~w_empty & bus.dec_ready;

  assign bus.pc_icache_ce = w_ce;
  assign bus.icache_addr  = r_pc;
  assign bus.dec_valid    = ~w_empty;
  assign bus.dec_inst     = w_head[INST_W+ADDR_W-1:ADDR_W];
  assign bus.dec_pc       = w_head[ADDR_W-1:0];
  assign bus.fq_count     = w_count;

  always_ff @(posedge clk) begin
    if (!rst)                    r_pc <= RESET_PC;
    else if (bus.redirect_valid) r_pc <= bus.redirect_pc;
    else if (w_accept)           r_pc <= r_pc + ADDR_W'(PC_INC);
  end

  fetch_fifo #(
    .W     (INST_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_din   ({bus.icache_dec_inst, r_pc}),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module : tb_fetch_unit
// Brief  : Randomized scoreboard bench for fetch_unit against a queue model
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int AW    = c_addr_w;
  localparam int IW    = c_inst_w;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [AW-1:0] TOP_PC = '1 << 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.INST_W(IW), .ADDR_W(AW), .CNT_W(CNT_W)) bus ();

  fetch_unit #(
    .INST_W(IW), .ADDR_W(AW), .DEPTH(DEPTH), .PC_INC(4), .RESET_PC(c_reset_pc)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_entry_t  sb[$];
  fetch_entry_t  mon_e;
  logic [AW-1:0] m_pc = c_reset_pc;
  int            n_tests = 0;
  int            n_fail  = 0;
  int p_en, p_stall, p_redir, p_ready, p_rst;
  bit force_top = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop must match the oldest expected fetch.
  always @(negedge clk) begin
    if (rst && !bus.redirect_valid && bus.dec_valid && bus.dec_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_empty: got pc %0h expected no entry", bus.dec_pc);
      end else begin
        mon_e = sb.pop_front();
        check("dec_pc", 64'(bus.dec_pc), 64'(mon_e.pc));
        check("dec_inst", 64'(bus.dec_inst), 64'(mon_e.inst));
      end
    end
  end

  task automatic step();
    logic exp_ce;
    @(posedge clk);
    #2;
    rst                   = ($urandom_range(99) >= p_rst);
    bus.icache_dec_enable = ($urandom_range(99) < p_en);
    bus.sta_icache_stall  = ($urandom_range(99) < p_stall);
    bus.redirect_valid    = ($urandom_range(99) < p_redir);
    bus.dec_ready         = ($urandom_range(99) < p_ready);
    bus.icache_dec_inst   = $urandom;
    if (force_top || $urandom_range(3) == 0) bus.redirect_pc = TOP_PC;
    else                                     bus.redirect_pc = AW'($urandom) & ~AW'(3);
    #1;
    exp_ce = rst && (sb.size() < DEPTH) && !bus.redirect_valid;
    check("ce", 64'(bus.pc_icache_ce), 64'(exp_ce));
    check("addr", 64'(bus.icache_addr), 64'(m_pc));
    check("dec_valid", 64'(bus.dec_valid), 64'(sb.size() != 0));
    check("fq_count", 64'(bus.fq_count), 64'(sb.size()));
    @(negedge clk);
    #1;
    if (!rst) begin
      sb.delete();
      m_pc = c_reset_pc;
    end else if (bus.redirect_valid) begin
      sb.delete();
      m_pc = bus.redirect_pc;
    end else if (exp_ce && bus.icache_dec_enable && !bus.sta_icache_stall) begin
      sb.push_back('{inst: bus.icache_dec_inst, pc: m_pc});
      m_pc = m_pc + AW'(4);
    end
  endtask

  task automatic phase(input int en, input int st, input int rd, input int ry,
                       input int rs, input int n);
    p_en = en; p_stall = st; p_redir = rd; p_ready = ry; p_rst = rs;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.icache_dec_enable = 1'b0;
    bus.sta_icache_stall  = 1'b0;
    bus.redirect_valid    = 1'b0;
    bus.redirect_pc       = '0;
    bus.dec_ready         = 1'b0;
    bus.icache_dec_inst   = '0;
    phase(100,   0,   0, 100, 100,   2);  // reset
    phase(100,   0,   0, 100,   0,  10);  // streaming hits
    phase(100,   0,   0,   0,   0,   8);  // fill until full
    phase(100,   0,   0, 100,   0,   6);  // drain and resume
    phase(100,  70,   0,  50,   0,  20);  // heavy stall
    phase( 90,  10,  20,  60,   0,  40);  // redirects mixed with hits and pops
    force_top = 1'b1;
    phase(100,   0, 100, 100,   0,   1);  // redirect to top of address space
    force_top = 1'b0;
    phase(100,   0,   0, 100,   0,   4);  // wrap to zero
    phase(100,   0,   0,   0,   0,   6);  // full queue
    phase(100, 100,   0,   0,   0,   3);  // stalled while full
    phase(100, 100,   0,   0, 100,   1);  // reset mid-stall
    phase(100,   0,   0, 100,   0,   4);
    phase( 80,  20,   5,  70,   2, 300);  // mixed random
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
